// File: rtl/irq_priority_encoder.sv
// -----------------------------------------------------------------------------
// irq_priority_encoder
//   Registered N-to-log2(N) priority encoder with sticky request capture.
//   Request lines are latched into a pending register. One pending index is
//   presented on code/valid and held until the consumer acks it. Selection is
//   either fixed (highest index wins) or round-robin, chosen by PRIO_MODE.
//
// Ports
//   clk    in   1   clock, all state updates on the rising edge
//   rst    in   1   synchronous active-high reset
//   req    in   N   request lines (level or pulse), sampled every edge
//   ack    in   1   consumer accepts current code; ignored while valid=0
//   valid  out  1   code holds a pending request index
//   code   out  W   encoded index of the selected request
//   pend   out  N   pending-request register (debug/status)
// -----------------------------------------------------------------------------
module irq_priority_encoder #(
  parameter  int N         = 8,
  parameter  int PRIO_MODE = 0,
  localparam int W         = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] code,
  output logic [N-1:0] pend
);

  logic [N-1:0] pend_q, pend_d;
  logic         valid_q, valid_d;
  logic [W-1:0] code_q, code_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         take_s;
  logic         update_s;
  logic         any_s;
  logic [N-1:0] clr_s;
  logic [N-1:0] cand_s;
  logic [W-1:0] sel_fixed_s;
  logic [W-1:0] sel_rr_s;
  logic [W-1:0] sel_s;
  logic [W-1:0] rr_base_s;
  logic [W-1:0] rr_idx_s;
  logic         rr_found_s;

  // Handshake decode and candidate vector (the acked bit is excluded).
  always_comb begin
    take_s = valid_q & ack;
    clr_s  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      clr_s[i] = take_s & (code_q == W'(i));
    end
    cand_s   = pend_q & ~clr_s;
    any_s    = |cand_s;
    update_s = ~valid_q | take_s;
  end

  // Fixed priority: scan upward so the highest set index is the last to land.
  always_comb begin
    sel_fixed_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      sel_fixed_s = cand_s[i] ? W'(i) : sel_fixed_s;
    end
  end

  // Round-robin: start just after the pointer (the code being acked when a
  // take happens) and wrap explicitly so the index never reaches N.
  always_comb begin
    rr_base_s  = take_s ? code_q : ptr_q;
    rr_idx_s   = rr_base_s;
    rr_found_s = 1'b0;
    sel_rr_s   = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      rr_idx_s = (rr_idx_s == W'(N - 1)) ? {W{1'b0}} : rr_idx_s + W'(1);
      if (!rr_found_s && cand_s[rr_idx_s]) begin
        sel_rr_s   = rr_idx_s;
        rr_found_s = 1'b1;
      end else begin
        sel_rr_s   = sel_rr_s;
        rr_found_s = rr_found_s;
      end
    end
  end

  // Next-state: set wins over clear on pend; outputs only reload when idle or
  // on a take, so a presented code is never preempted.
  always_comb begin
    sel_s  = (PRIO_MODE == 1) ? sel_rr_s : sel_fixed_s;
    pend_d = (pend_q & ~clr_s) | req;
    if (update_s) begin
      valid_d = any_s;
      code_d  = any_s ? sel_s : {W{1'b0}};
    end else begin
      valid_d = valid_q;
      code_d  = code_q;
    end
    ptr_d = take_s ? code_q : ptr_q;
  end

  // State registers with synchronous reset; req/ack are ignored on a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= {N{1'b0}};
      valid_q <= 1'b0;
      code_q  <= {W{1'b0}};
      ptr_q   <= W'(N - 1);
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid = valid_q;
  assign code  = code_q;
  assign pend  = pend_q;

endmodule
